// File: rtl/wb_wbuf_pkg.sv
// rtl/wb_wbuf_pkg.sv - shared types and constants for the Wishbone write-posting buffer
package wb_wbuf_pkg;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } m_state_e;

  localparam int WBUF_ENTRY_W = 68;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wbuf_entry_t;

endpackage

// File: rtl/wb_wbuf_fifo.sv
// rtl/wb_wbuf_fifo.sv - circular FIFO with combinational head read
// Only pointers and count are reset; storage contents are don't-care until written.
module wb_wbuf_fifo #(
  parameter int width      = 68,
  parameter int depth_log2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [width-1:0]      din_i,
  output logic [width-1:0]      dout_o,
  output logic [depth_log2:0]   count_o
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_CNT = DEPTH[depth_log2:0];

  logic [width-1:0]      mem_q [DEPTH];
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [depth_log2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i & (count_q != FULL_CNT);
  assign pop_ok  = pop_i & (count_q != '0);

  always_comb begin
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_wbuf.sv
// rtl/wb_wbuf.sv - posts CPU writes into a FIFO and drains them to the SRAM controller
// Reads wait until the FIFO is empty so they always observe earlier posted writes.
module wb_wbuf
  import wb_wbuf_pkg::*;
#(
  parameter int depth_log2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  input  logic        s_we_i,
  input  logic [31:0] s_adr_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_dat_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        empty_o
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_CNT = DEPTH[depth_log2:0];

  m_state_e            state_q, state_d;
  logic                s_ack_q, s_ack_d;
  logic [31:0]         s_dat_q, s_dat_d;
  logic                m_stb_q, m_stb_d, m_we_q, m_we_d;
  logic [31:0]         m_adr_q, m_adr_d, m_dat_q, m_dat_d;
  logic [3:0]          m_sel_q, m_sel_d;
  logic                s_wr, s_rd, push, pop;
  logic [depth_log2:0] count;
  wbuf_entry_t         din, head;

  assign s_wr = s_stb_i & s_cyc_i & s_we_i & ~s_ack_q;
  assign s_rd = s_stb_i & s_cyc_i & ~s_we_i & ~s_ack_q;
  // Fullness from the registered count: a pop this edge does not free a slot until next edge.
  assign push = s_wr & (count != FULL_CNT);
  assign pop  = (state_q == M_WRITE) & m_ack_i;
  assign din  = {s_adr_i, s_sel_i, s_dat_i};

  wb_wbuf_fifo #(
    .width      (WBUF_ENTRY_W),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= M_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE: begin
        if (count != '0) state_d = M_WRITE;
        else if (s_rd)   state_d = M_READ;
      end
      M_WRITE, M_READ: if (m_ack_i) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    s_ack_d = push;
    s_dat_d = s_dat_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_sel_d = m_sel_q;
    m_dat_d = m_dat_q;
    case (state_q)
      M_IDLE: begin
        if (count != '0) begin
          m_stb_d = 1'b1;
          m_we_d  = 1'b1;
          m_adr_d = head.adr;
          m_sel_d = head.sel;
          m_dat_d = head.dat;
        end else if (s_rd) begin
          m_stb_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = s_adr_i;
          m_sel_d = s_sel_i;
        end
      end
      M_WRITE: if (m_ack_i) m_stb_d = 1'b0;
      M_READ: begin
        if (m_ack_i) begin
          m_stb_d = 1'b0;
          s_ack_d = 1'b1;
          s_dat_d = m_dat_i;
        end
      end
      default: m_stb_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ack_q <= 1'b0;
      s_dat_q <= '0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_sel_q <= '0;
      m_dat_q <= '0;
    end else begin
      s_ack_q <= s_ack_d;
      s_dat_q <= s_dat_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_sel_q <= m_sel_d;
      m_dat_q <= m_dat_d;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_stb_o = m_stb_q;
  assign m_cyc_o = m_stb_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_sel_o = m_sel_q;
  assign m_dat_o = m_dat_q;
  assign empty_o = (count == '0) & (state_q == M_IDLE);

endmodule

// File: tb/tb_wb_wbuf.sv
// tb/tb_wb_wbuf.sv - randomized bench for wb_wbuf against a transaction-level model
module tb_wb_wbuf;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_stb_i, s_cyc_i, s_we_i;
  logic [31:0] s_adr_i, s_dat_i;
  logic [3:0]  s_sel_i;
  logic        s_ack_o;
  logic [31:0] s_dat_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i;
  logic [31:0] m_dat_i;
  logic        empty_o;

  wb_wbuf dut (
    .clk(clk), .reset_n(reset_n),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_we_i(s_we_i),
    .s_adr_i(s_adr_i), .s_sel_i(s_sel_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_dat_i(m_dat_i), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises = 0;
  int ack_delay = 0;
  int read_rise_cyc = 0;

  logic [31:0] cpu_mem [logic [31:0]];
  logic [31:0] sram    [logic [31:0]];
  ent_t        expq[$];
  logic [31:0] wlog[$];
  int          pop_cycs[$];
  int          ack_cycs[$];

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] cpu_rd(input logic [31:0] a);
    return cpu_mem.exists(a) ? cpu_mem[a] : ~a;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : ~a;
  endfunction

  // SRAM slave: acks after ack_delay wait cycles, one-cycle ack pulse.
  initial begin
    int w = 0;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        m_ack_i = 1'b0;
        w = 0;
      end else if (m_ack_i) begin
        m_ack_i = 1'b0;
      end else if (m_stb_o) begin
        if (w >= ack_delay) begin
          m_ack_i = 1'b1;
          w = 0;
          if (m_we_o) sram[m_adr_o] = merge(sram_rd(m_adr_o), m_dat_o, m_sel_o);
          else        m_dat_i = sram_rd(m_adr_o);
        end else w++;
      end
    end
  end

  // Model state: occ is the number of posted-but-not-drained writes.
  int          occ = 0;
  logic        p_push = 0, p_pop = 0, p_rdack = 0, p_stb = 0, p_mack = 0, p_rd = 0, p_we = 0;
  ent_t        p_ent;
  logic [31:0] p_rdexp, p_adr, p_dat, p_adr_in;
  logic [3:0]  p_sel, p_sel_in;

  always @(negedge clk) begin : monitor
    logic wr, rd, exp_stb;
    cyc++;
    if (!reset_n) begin
      occ = 0;
      expq.delete();
      p_push = 0; p_pop = 0; p_rdack = 0; p_stb = 0; p_mack = 0; p_rd = 0;
    end else begin
      chk("s_ack", s_ack_o, p_push | p_rdack);
      if (p_rdack) chk("s_dat", s_dat_o, p_rdexp);
      if (s_ack_o) ack_cycs.push_back(cyc);
      exp_stb = p_stb ? !p_mack : (occ > 0 || p_rd);
      chk("m_stb", m_stb_o, exp_stb);
      chk("m_cyc", m_cyc_o, exp_stb);
      if (p_pop && expq.size() > 0) void'(expq.pop_front());
      if (m_stb_o && !p_stb) begin
        rises++;
        chk("m_we_rise", m_we_o, occ > 0);
        if (m_we_o) begin
          if (expq.size() == 0) chk("m_wr_unexpected", 0, 1);
          else chk("m_wr_entry", {m_adr_o, m_sel_o, m_dat_o}, expq[0]);
          wlog.push_back(m_adr_o);
        end else begin
          chk("m_rd_req", {m_adr_o, m_sel_o}, {p_adr_in, p_sel_in});
          read_rise_cyc = cyc;
        end
      end else if (m_stb_o && p_stb) begin
        chk("m_hold", {m_we_o, m_adr_o, m_sel_o, m_dat_o}, {p_we, p_adr, p_sel, p_dat});
      end
      occ = occ + int'(p_push) - int'(p_pop);
      if (p_push) expq.push_back(p_ent);
      chk("empty", empty_o, occ == 0 && !m_stb_o);
      chk("occ_bound", occ <= DEPTH, 1);

      wr = s_stb_i && s_cyc_i && s_we_i && !s_ack_o;
      rd = s_stb_i && s_cyc_i && !s_we_i && !s_ack_o;
      p_push = wr && (occ < DEPTH);
      p_ent  = {s_adr_i, s_sel_i, s_dat_i};
      if (p_push) cpu_mem[s_adr_i] = merge(cpu_rd(s_adr_i), s_dat_i, s_sel_i);
      p_mack  = m_ack_i && m_stb_o;
      p_pop   = p_mack && m_we_o;
      p_rdack = p_mack && !m_we_o;
      if (p_pop) pop_cycs.push_back(cyc);
      p_rdexp = cpu_rd(m_adr_o);
      p_rd = rd; p_stb = m_stb_o; p_we = m_we_o;
      p_adr = m_adr_o; p_sel = m_sel_o; p_dat = m_dat_o;
      p_adr_in = s_adr_i; p_sel_in = s_sel_i;
    end
  end

  task automatic cpu_idle();
    s_stb_i = 0; s_cyc_i = 0; s_we_i = 0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    s_stb_i = 1; s_cyc_i = 1; s_we_i = 1; s_adr_i = a; s_sel_i = s; s_dat_i = d;
    do begin @(posedge clk); #1; n++; end while (!s_ack_o && n < 500);
    if (!s_ack_o) chk("wr_timeout", 0, 1);
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    s_stb_i = 1; s_cyc_i = 1; s_we_i = 0; s_adr_i = a; s_sel_i = 4'hF;
    do begin @(posedge clk); #1; n++; end while (!s_ack_o && n < 500);
    if (!s_ack_o) chk("rd_timeout", 0, 1);
    d = s_dat_o;
    cpu_idle();
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!empty_o && n < 500) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    if (!empty_o) chk("empty_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_s_ack"}, s_ack_o, 0);
    chk({nm, "_s_dat"}, s_dat_o, 0);
    chk({nm, "_m_ctl"}, {m_stb_o, m_cyc_o, m_we_o}, 0);
    chk({nm, "_m_adr"}, m_adr_o, 0);
    chk({nm, "_m_sel"}, m_sel_o, 0);
    chk({nm, "_m_dat"}, m_dat_o, 0);
    chk({nm, "_empty"}, empty_o, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdat;
    logic [3:0]  sels [12] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h3, 4'hC, 4'h6, 4'h9};
    logic [31:0] t2adr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    int snap;
    reset_n = 0;
    s_adr_i = 0; s_sel_i = 0; s_dat_i = 0;
    cpu_idle();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("init");
    #2 reset_n = 1;

    // Single posted write.
    wlog.delete();
    cpu_write(32'h100, 4'hF, 32'hDEADBEEF);
    cpu_idle();
    wait_empty();
    chk("t1_nwr", wlog.size(), 1);
    if (wlog.size() == 1) chk("t1_adr", wlog[0], 32'h100);
    chk("t1_sram", sram_rd(32'h100), 32'hDEADBEEF);

    // Five back-to-back writes with a slow SRAM: the fifth stalls until the first pop.
    wlog.delete(); pop_cycs.delete(); ack_cycs.delete();
    ack_delay = 10;
    for (int i = 0; i < 5; i++) cpu_write(t2adr[i], 4'hF, 32'hA0 + i);
    cpu_idle();
    wait_empty();
    chk("t2_nwr", wlog.size(), 5);
    for (int i = 0; i < 5; i++) if (i < wlog.size()) chk("t2_order", wlog[i], t2adr[i]);
    if (ack_cycs.size() >= 5 && pop_cycs.size() >= 1)
      chk("t2_ack5_cyc", ack_cycs[4], pop_cycs[0] + 2);
    else chk("t2_events", 0, 1);

    // Read after three queued writes sees the freshly written data.
    pop_cycs.delete();
    ack_delay = 2;
    cpu_write(32'h0, 4'hF, 32'h11111111);
    cpu_write(32'h4, 4'hF, 32'h22222222);
    cpu_write(32'h8, 4'hF, 32'h33333333);
    cpu_read(32'h4, rdat);
    chk("t3_rdat", rdat, 32'h22222222);
    if (pop_cycs.size() == 3) chk("t3_rd_after_pops", read_rise_cyc, pop_cycs[2] + 2);
    else chk("t3_npops", pop_cycs.size(), 3);
    wait_empty();

    // Pointer wrap with assorted byte selects.
    wlog.delete();
    ack_delay = 1;
    for (int i = 0; i < 12; i++) begin
      cpu_write(32'h200 + 4 * i, sels[i], 32'h5A000000 + i);
      cpu_idle();
      wait_empty();
    end
    chk("t4_nwr", wlog.size(), 12);
    for (int i = 0; i < 12; i++) if (i < wlog.size()) chk("t4_order", wlog[i], 32'h200 + 4 * i);
    chk("t4_sel3", sram_rd(32'h204), merge(32'hFFFFFDFB, 32'h5A000001, 4'h3));

    // Random mix of writes and reads, random SRAM latency.
    for (int k = 0; k < 300; k++) begin
      ack_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 9) < 7)
        cpu_write(32'h4 * $urandom_range(0, 15), 4'($urandom_range(1, 15)), $urandom);
      else
        cpu_read(32'h4 * $urandom_range(0, 15), rdat);
      if ($urandom_range(0, 1) == 1) begin
        cpu_idle();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    cpu_idle();
    wait_empty();

    // Asynchronous reset mid-write with entries still queued.
    ack_delay = 50;
    cpu_write(32'h300, 4'hF, 32'h1);
    cpu_write(32'h304, 4'hF, 32'h2);
    cpu_write(32'h308, 4'hF, 32'h3);
    cpu_idle();
    repeat (3) @(posedge clk);
    chk("t6_busy", {m_stb_o, m_adr_o}, {1'b1, 32'h300});
    #3 reset_n = 0;
    #1 chk_reset_vals("t6");
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    snap = rises;
    ack_delay = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_strobes", rises - snap, 0);
    chk("t6_empty", empty_o, 1);
    cpu_mem = sram;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
